uart_sender_arbiter: RTL and testbench
======================================

// Module: uart_sender_arbiter
// PURPOSE
// - Shares the single UART element sender (number formatter/TX) between NUM_REQ print clients
//   (input echo, matrix display, calculator result).
// - A granted client owns the sender for a whole session (e.g. one full matrix print), not per element.
// - Round-robin grant, per-session lock, watchdog that recovers from a client or sender that hangs.
// PARAMETERS
// NUM_REQ        3           number of requesters; client 0 = echo, 1 = display, 2 = result
// TIMEOUT_CYCLES 50_000_000  max cycles a single element send may stay in flight (500 ms @ 100 MHz)
// PORTS
// clk                i  1          system clock, 100 MHz
// rst_n              i  1          asynchronous, active-low reset
// req                i  NUM_REQ    level request per client; held high for the whole session
// cli_start          i  NUM_REQ    per-client 1-cycle send pulse
// cli_data           i  NUM_REQ*32 per-client matrix_element_t; client i uses bits [32i+31:32i]
// cli_is_last_col    i  NUM_REQ    per-client flag: end the line after this element
// cli_newline_only   i  NUM_REQ    per-client flag: send CR/LF only
// cli_id             i  NUM_REQ    per-client flag: value is a matrix ID
// grant              o  NUM_REQ    one-hot session grant; all zero when idle
// cli_ready          o  NUM_REQ    sender_ready gated to the granted client; 0 for all others
// cli_done           o  NUM_REQ    sender_done routed to the granted client only
// sender_start       o  1          start pulse to the sender
// sender_data        o  32         element to the sender
// sender_is_last_col o  1          forwarded flag
// sender_newline_only o 1          forwarded flag
// sender_id          o  1          forwarded flag
// sender_ready       i  1          sender can accept a start
// sender_done        i  1          1-cycle pulse when the sender finishes an element
// illegal_start      o  1          1-cycle pulse: cli_start seen from a non-granted client
// timeout            o  1          1-cycle pulse: watchdog fired and the session was aborted
// BEHAVIOUR
// - Reset: state=IDLE; grant=0, rr_ptr=0, timer=0.
//   All outputs are 0, including sender_start, sender_data and the flags.
// - FSM states: IDLE, OWNED, IN_FLIGHT, DRAIN.
// - IDLE
//   - If any req bit is high, choose the first requester at or after rr_ptr (modulo NUM_REQ).
//   - Register grant one-hot; go to OWNED. Grant is visible 1 cycle after req.
// - OWNED
//   - Forward sender_data and the three flags combinationally from the granted client.
//   - sender_start = cli_start[g] & sender_ready.
//   - When sender_start fires: go to IN_FLIGHT and clear timer.
//   - If cli_start[g] arrives while sender_ready=0, drop it; the client must wait for cli_ready.
//   - If req[g] falls and no start is issued this cycle: grant <= 0, rr_ptr <= g+1 (wrapping), go to IDLE.
// - IN_FLIGHT
//   - Timer increments every cycle.
//   - On sender_done: pulse cli_done[g]. If req[g]=1, go to OWNED; otherwise release as above and go to IDLE.
//   - If timer reaches TIMEOUT_CYCLES: pulse timeout, go to DRAIN.
// - DRAIN
//   - grant=0. Wait for sender_ready=1, then rr_ptr <= g+1 and go to IDLE.
//   - A late sender_done in DRAIN is swallowed; no cli_done is issued.
// - Flags are held stable from the start cycle through done, matching what the sender expects.
// - Simultaneous events
//   - A start in the same cycle req[g] falls is honoured; the session ends after that element's done.
//   - Multiple new reqs while another client is owned: they wait; no preemption.
// - Fairness: after a release, the pointer is just past the last owner, so every requester is served
//   within NUM_REQ sessions.
// - illegal_start: pulses for any cli_start[i] where grant[i]=0. The pulse is ignored by the datapath.
// - rst_n asserted mid-send: everything returns to its reset value at once. sender_start is never
//   re-issued after reset release.
// - Widths: rr_ptr is $clog2(NUM_REQ) bits; timer is 26 bits and saturates at TIMEOUT_CYCLES.
// TESTING
// - Single client: req[1]=1, 4 starts for data 5,-3,7,0 with last_col on the 4th.
//   Expect exactly 4 sender_start pulses with matching data and 4 cli_done[1] pulses.
// - Contention: req=3'b111 from reset, each session sends 1 element then drops req.
//   Grant order must be 0,1,2; after re-raising, order 0,1,2 again.
// - Lock: client 0 is owned and mid-session while req[2] rises.
//   grant[2] stays 0 until req[0] falls; then grant=3'b100 exactly 1 cycle later.
// - Stray start: grant=3'b001, cli_start[1] pulses.
//   Expect illegal_start=1 for 1 cycle and sender_start=0.
// - Watchdog: send once, hold sender_done=0 for TIMEOUT_CYCLES (use a small parameter, e.g. 16).
//   Expect a timeout pulse, grant->0, and the next requester granted once sender_ready=1.
// - Reset mid IN_FLIGHT: assert rst_n=0 for 1 cycle.
//   Expect grant=0, no cli_done, no sender_start after release, with req held.

Source files
------------

// File: rtl/uart_sender_arbiter.sv
// Shares one UART element sender between NUM_REQ print clients.
// A client keeps the sender for a whole session (round-robin pick, no preemption);
// a watchdog aborts a session whose element send never completes.
module uart_sender_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    cli_start,
  input  logic [NUM_REQ*32-1:0] cli_data,
  input  logic [NUM_REQ-1:0]    cli_is_last_col,
  input  logic [NUM_REQ-1:0]    cli_newline_only,
  input  logic [NUM_REQ-1:0]    cli_id,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    cli_ready,
  output logic [NUM_REQ-1:0]    cli_done,
  output logic                  sender_start,
  output logic [31:0]           sender_data,
  output logic                  sender_is_last_col,
  output logic                  sender_newline_only,
  output logic                  sender_id,
  input  logic                  sender_ready,
  input  logic                  sender_done,
  output logic                  illegal_start,
  output logic                  timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [25:0]   TIMEOUT_VAL = 26'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, OWNED, IN_FLIGHT, DRAIN} state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [IW-1:0]      rr_ptr_reg;
  logic [IW-1:0]      owner_reg;
  logic [25:0]        timer_reg;
  // Element and flags captured at the start so they stay stable until done
  logic [31:0]        data_hold_reg;
  logic               last_hold_reg;
  logic               nl_hold_reg;
  logic               id_hold_reg;

  logic               owned;
  logic               in_flight;
  logic               start_fire;
  logic               done_fire;
  logic               timeout_fire;
  logic [IW-1:0]      ptr_after_owner;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  int unsigned        idx;
  logic [31:0]        cli_word [NUM_REQ];

  assign owned        = (state_reg == OWNED);
  assign in_flight    = (state_reg == IN_FLIGHT);
  assign start_fire   = owned && cli_start[owner_reg] && sender_ready;
  assign done_fire    = in_flight && sender_done;
  // A done arriving in the same cycle as the deadline wins over the abort
  assign timeout_fire = in_flight && !sender_done && (timer_reg == TIMEOUT_VAL);
  assign ptr_after_owner = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;

  assign grant         = grant_reg;
  assign sender_start  = start_fire;
  assign timeout       = timeout_fire;
  assign illegal_start = |(cli_start & ~grant_reg);

  // Per-client data slices and gated handshake outputs
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cli
      assign cli_word[gi]  = cli_data[32*gi +: 32];
      assign cli_ready[gi] = owned && grant_reg[gi] && sender_ready;
      assign cli_done[gi]  = done_fire && grant_reg[gi];
    end
  endgenerate

  // Round-robin pick: first requester at or after rr_ptr, wrapping
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_reg) + i) % NUM_REQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  // Sender datapath: live from the owner while waiting, held copy while in flight
  always_comb begin
    sender_data         = '0;
    sender_is_last_col  = 1'b0;
    sender_newline_only = 1'b0;
    sender_id           = 1'b0;
    if (owned) begin
      sender_data         = cli_word[owner_reg];
      sender_is_last_col  = cli_is_last_col[owner_reg];
      sender_newline_only = cli_newline_only[owner_reg];
      sender_id           = cli_id[owner_reg];
    end else if (in_flight) begin
      sender_data         = data_hold_reg;
      sender_is_last_col  = last_hold_reg;
      sender_newline_only = nl_hold_reg;
      sender_id           = id_hold_reg;
    end
  end

  // Session FSM: grant, lock, per-element watchdog and drain after an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      timer_reg     <= '0;
      data_hold_reg <= '0;
      last_hold_reg <= 1'b0;
      nl_hold_reg   <= 1'b0;
      id_hold_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg <= NUM_REQ'(1) << pick_idx;
            owner_reg <= pick_idx;
            state_reg <= OWNED;
          end
        end
        OWNED: begin
          if (start_fire) begin
            timer_reg     <= '0;
            data_hold_reg <= cli_word[owner_reg];
            last_hold_reg <= cli_is_last_col[owner_reg];
            nl_hold_reg   <= cli_newline_only[owner_reg];
            id_hold_reg   <= cli_id[owner_reg];
            state_reg     <= IN_FLIGHT;
          end else if (!req[owner_reg]) begin
            grant_reg  <= '0;
            rr_ptr_reg <= ptr_after_owner;
            state_reg  <= IDLE;
          end
        end
        IN_FLIGHT: begin
          if (timer_reg != TIMEOUT_VAL) begin
            timer_reg <= timer_reg + 26'd1;
          end
          if (sender_done) begin
            if (req[owner_reg]) begin
              state_reg <= OWNED;
            end else begin
              grant_reg  <= '0;
              rr_ptr_reg <= ptr_after_owner;
              state_reg  <= IDLE;
            end
          end else if (timeout_fire) begin
            grant_reg <= '0;
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (sender_ready) begin
            rr_ptr_reg <= ptr_after_owner;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender_arbiter.sv
// Scoreboard bench for uart_sender_arbiter: stimulus pushes expected starts,
// dones and grants into queues; a negedge monitor pops and compares.
module tb_uart_sender_arbiter;

  localparam int NUM_REQ = 3;
  localparam int TO      = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  cli_start = '0;
  logic [95:0] cli_data = '0;
  logic [2:0]  cli_is_last_col = '0;
  logic [2:0]  cli_newline_only = '0;
  logic [2:0]  cli_id = '0;
  logic [2:0]  grant;
  logic [2:0]  cli_ready;
  logic [2:0]  cli_done;
  logic        sender_start;
  logic [31:0] sender_data;
  logic        sender_is_last_col;
  logic        sender_newline_only;
  logic        sender_id;
  logic        sender_ready = 1'b1;
  logic        sender_done = 1'b0;
  logic        illegal_start;
  logic        timeout;

  uart_sender_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cli_start(cli_start), .cli_data(cli_data),
    .cli_is_last_col(cli_is_last_col), .cli_newline_only(cli_newline_only), .cli_id(cli_id),
    .grant(grant), .cli_ready(cli_ready), .cli_done(cli_done), .sender_start(sender_start),
    .sender_data(sender_data), .sender_is_last_col(sender_is_last_col),
    .sender_newline_only(sender_newline_only), .sender_id(sender_id),
    .sender_ready(sender_ready), .sender_done(sender_done),
    .illegal_start(illegal_start), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        nl;
    logic        id;
    logic [2:0]  g;
  } xfer_t;

  xfer_t      exp_start_q[$];
  int         exp_done_q[$];
  logic [2:0] exp_grant_q[$];
  xfer_t      cur_x = '0;
  int         done_idx;
  logic [2:0] prev_grant = '0;
  int errors = 0, checks = 0;
  int start_count = 0, done_count = 0, timeout_count = 0, illegal_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural sender: busy for lat cycles after a start, frozen while hang=1
  bit start_seen = 1'b0;
  bit hang = 1'b0;
  int busy = 0;
  int lat = 2;
  always @(negedge clk) start_seen = sender_start;
  always @(posedge clk) begin
    #1;
    sender_done = 1'b0;
    if (start_seen) begin
      busy = lat;
      sender_ready = 1'b0;
    end else if (busy > 0 && !hang) begin
      busy--;
      if (busy == 0) begin
        sender_done = 1'b1;
        sender_ready = 1'b1;
      end
    end
  end

  // Monitor: compare every start, done and new grant against the scoreboard
  always @(negedge clk) begin
    if (sender_start === 1'b1) begin
      start_count++;
      if (exp_start_q.size() == 0) chk("unexpected_sender_start", sender_start, 0);
      else begin
        cur_x = exp_start_q.pop_front();
        chk("start_data", sender_data, cur_x.data);
        chk("start_flags", {sender_is_last_col, sender_newline_only, sender_id},
            {cur_x.last, cur_x.nl, cur_x.id});
        chk("start_grant", grant, cur_x.g);
      end
    end
    if (cli_done !== 3'b000) begin
      done_count++;
      if (exp_done_q.size() == 0) chk("unexpected_cli_done", cli_done, 0);
      else begin
        done_idx = exp_done_q.pop_front();
        chk("cli_done", cli_done, 3'b001 << done_idx);
        chk("held_data", sender_data, cur_x.data);
        chk("held_flags", {sender_is_last_col, sender_newline_only, sender_id},
            {cur_x.last, cur_x.nl, cur_x.id});
      end
    end
    if (grant !== prev_grant && grant !== 3'b000) begin
      if (exp_grant_q.size() == 0) chk("unexpected_grant", grant, 0);
      else chk("grant_order", grant, exp_grant_q.pop_front());
    end
    prev_grant = grant;
    if (timeout === 1'b1) timeout_count++;
    if (illegal_start === 1'b1) illegal_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cli_ready[c] !== 1'b1 && n < 200);
    if (cli_ready[c] !== 1'b1) chk("wait_ready", cli_ready[c], 1'b1);
  endtask

  task automatic wait_done(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cli_done[c] !== 1'b1 && n < 200);
    if (cli_done[c] !== 1'b1) chk("wait_done", cli_done[c], 1'b1);
  endtask

  // One element from client c; afterwards the client's inputs are scrambled
  // so that any forwarding of live data during the send shows up at done.
  task automatic send(input int c, input logic [31:0] d, input logic l, input logic nl_f,
                      input logic id_f, input bit exp_done);
    xfer_t x;
    wait_ready(c);
    tick();
    cli_data[32*c +: 32] = d;
    cli_is_last_col[c]   = l;
    cli_newline_only[c]  = nl_f;
    cli_id[c]            = id_f;
    cli_start[c]         = 1'b1;
    x.data = d; x.last = l; x.nl = nl_f; x.id = id_f; x.g = 3'b001 << c;
    exp_start_q.push_back(x);
    if (exp_done) exp_done_q.push_back(c);
    tick();
    cli_start[c]         = 1'b0;
    cli_data[32*c +: 32] = ~d;
    cli_is_last_col[c]   = ~l;
    cli_newline_only[c]  = ~nl_f;
    cli_id[c]            = ~id_f;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int sc0, dc0, ic0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_start", sender_start, 0);
    chk("rst_data", sender_data, 0);
    chk("rst_flags", {sender_is_last_col, sender_newline_only, sender_id}, 0);
    chk("rst_ready_done", {cli_ready, cli_done}, 0);
    chk("rst_pulses", {timeout, illegal_start}, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_grant", grant, 0);

    // Single client session: 4 elements from client 1
    sc0 = start_count; dc0 = done_count;
    tick();
    req[1] = 1'b1;
    exp_grant_q.push_back(3'b010);
    send(1, 32'd5, 1'b0, 1'b0, 1'b0, 1); wait_done(1);
    send(1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, 1); wait_done(1);
    send(1, 32'd7, 1'b0, 1'b1, 1'b0, 1); wait_done(1);
    send(1, 32'd0, 1'b1, 1'b0, 1'b0, 1); wait_done(1);
    tick();
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("single_release_grant", grant, 0);
    chk("single_start_count", start_count - sc0, 4);
    chk("single_done_count", done_count - dc0, 4);

    // Contention from reset: order 0,1,2 twice
    tick();
    rst_n = 1'b0;
    req = 3'b111;
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 3; c++) exp_grant_q.push_back(3'b001 << c);
      for (int c = 0; c < 3; c++) begin
        send(c, 32'h100 + 32'(p * 16 + c), 1'b1, 1'b0, 1'b0, 1);
        wait_done(c);
        tick();
        req[c] = 1'b0;
      end
      repeat (2) tick();
      if (p == 0) req = 3'b111;
    end

    // Lock: client 0 keeps the sender while client 2 waits
    tick();
    req[0] = 1'b1;
    exp_grant_q.push_back(3'b001);
    send(0, 32'h11, 1'b0, 1'b0, 1'b0, 1); wait_done(0);
    tick();
    req[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("lock_hold", grant, 3'b001);
    chk("ready_gated", cli_ready, 3'b001);
    // Stray start from non-granted client 1
    ic0 = illegal_count;
    tick();
    cli_start[1] = 1'b1;
    @(negedge clk);
    chk("stray_illegal", illegal_start, 1'b1);
    chk("stray_no_start", sender_start, 1'b0);
    tick();
    cli_start[1] = 1'b0;
    @(negedge clk);
    chk("stray_pulse_end", illegal_start, 1'b0);
    chk("stray_count", illegal_count - ic0, 1);
    send(0, 32'h22, 1'b1, 1'b0, 1'b0, 1); wait_done(0);
    @(negedge clk);
    chk("lock_after_second", grant, 3'b001);
    exp_grant_q.push_back(3'b100);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    chk("handoff_same_cycle", grant, 3'b001);
    @(negedge clk);
    chk("handoff_released", grant, 3'b000);
    @(negedge clk);
    chk("handoff_grant2", grant, 3'b100);
    tick();
    req[2] = 1'b0;
    repeat (2) tick();

    // Watchdog: sender hangs after the start
    hang = 1'b1;
    req = 3'b110;
    exp_grant_q.push_back(3'b010);
    send(1, 32'hABCD, 1'b0, 1'b0, 1'b0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timeout !== 1'b1 && n < 60);
    chk("timeout_latency", n, TO + 1);
    @(negedge clk);
    chk("drain_grant", grant, 3'b000);
    chk("timeout_pulse_end", timeout, 1'b0);
    repeat (3) @(negedge clk);
    chk("drain_hold", grant, 3'b000);
    exp_grant_q.push_back(3'b100);
    tick();
    hang = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant !== 3'b100 && n < 30);
    chk("after_drain_grant", grant, 3'b100);
    chk("timeout_count", timeout_count, 1);
    tick();
    req = 3'b000;
    repeat (3) tick();

    // Reset while an element is in flight
    lat = 8;
    req[0] = 1'b1;
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b001);
    send(0, 32'h55, 1'b0, 1'b0, 1'b0, 0);
    sc0 = start_count; dc0 = done_count;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_grant", grant, 3'b000);
    chk("midrst_outputs", {sender_start, cli_done, timeout}, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_start", start_count - sc0, 0);
    chk("midrst_no_done", done_count - dc0, 0);
    chk("midrst_regrant", grant, 3'b001);
    tick();
    req = 3'b000;
    repeat (3) tick();

    chk("start_queue_empty", exp_start_q.size(), 0);
    chk("done_queue_empty", exp_done_q.size(), 0);
    chk("grant_queue_empty", exp_grant_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
